// File: rtl/block_dispatcher_pkg.sv
// Shared definitions for the block dispatcher: data width, FSM encoding and
// the block-count helper used when a kernel is latched.
package block_dispatcher_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    DISP_IDLE = 2'd0,
    DISP_RUN  = 2'd1,
    DISP_DONE = 2'd2
  } disp_state_e;

  // Ceiling division by a power-of-two block size. The sum is kept in 9 bits
  // so 255 threads do not wrap before the shift.
  function automatic logic [DATA_W-1:0] blocks_for(input logic [DATA_W-1:0] threads,
                                                   input int tpb_log2);
    logic [DATA_W:0] sum;
    sum = {1'b0, threads} + ((9'd1 << tpb_log2) - 9'd1);
    return DATA_W'(sum >> tpb_log2);
  endfunction

endpackage

// File: rtl/block_dispatcher_if.sv
// Host/core-facing bundle of the block dispatcher. slave = dispatcher side,
// master = host, dcr and compute cores.
interface block_dispatcher_if #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
);
    import block_dispatcher_pkg::*;

    localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

    // Handshake: start is a level request sampled in IDLE. core_start[i] high
    // means a block is in flight on core i; core_done[i] is only honoured while
    // core_start[i] is high and completes that block on the sampling edge.
    logic                        start;
    logic [DATA_W-1:0]           thread_count;
    logic [NUM_CORES-1:0]        core_done;
    logic [NUM_CORES-1:0]        core_start;
    logic [NUM_CORES-1:0]        core_reset;
    logic [NUM_CORES*DATA_W-1:0] core_block_id;
    logic [NUM_CORES*TCW-1:0]    core_thread_count;
    logic                        done;
    disp_state_e                 dbg_state;

    modport slave (
        input  start, thread_count, core_done,
        output core_start, core_reset, core_block_id, core_thread_count, done, dbg_state
    );

    modport master (
        output start, thread_count, core_done,
        input  core_start, core_reset, core_block_id, core_thread_count, done, dbg_state
    );

endinterface

// File: rtl/block_dispatcher_picker.sv
// Combinational priority picker: reports whether any core is idle and the
// lowest index among the idle ones.
module idle_core_picker #(
    parameter int NUM_CORES = 2,
    parameter int IW        = 1
) (
    input  logic [NUM_CORES-1:0] mask,
    output logic                 valid,
    output logic [IW-1:0]        idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/block_dispatcher.sv
// Splits a kernel of thread_count threads into fixed-size blocks, hands them to
// idle cores one per cycle and raises done once every block has completed.
module block_dispatcher
    import block_dispatcher_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic               clk,
    input  logic               reset,
    block_dispatcher_if.slave  bus
);

    localparam int TCW      = $clog2(THREADS_PER_BLOCK) + 1;
    localparam int TPB_LOG2 = $clog2(THREADS_PER_BLOCK);
    localparam int IW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [TCW-1:0] FULL_TC = TCW'(THREADS_PER_BLOCK);

    disp_state_e                 state_q, state_d;
    logic [DATA_W-1:0]           total_q, total_d;
    logic [DATA_W-1:0]           count_q, count_d;
    logic [DATA_W-1:0]           dispatched_q, dispatched_d;
    logic [DATA_W-1:0]           completed_q, completed_d;
    logic [NUM_CORES-1:0]        core_start_q, core_start_d;
    logic [NUM_CORES-1:0]        core_reset_q, core_reset_d;
    logic [NUM_CORES*DATA_W-1:0] block_id_q, block_id_d;
    logic [NUM_CORES*TCW-1:0]    tc_q, tc_d;
    logic                        done_q, done_d;

    logic                        pick_valid;
    logic [IW-1:0]               pick_idx;

    logic [NUM_CORES-1:0]        comp;
    logic [DATA_W-1:0]           n_comp;
    logic [DATA_W-1:0]           new_total;
    logic [15:0]                 last_base;
    logic [TCW-1:0]              last_tc;
    int                          sel;

    idle_core_picker #(
        .NUM_CORES (NUM_CORES),
        .IW        (IW)
    ) u_picker (
        .mask  (core_reset_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        count_d      = count_q;
        dispatched_d = dispatched_q;
        completed_d  = completed_q;
        core_start_d = core_start_q;
        core_reset_d = core_reset_q;
        block_id_d   = block_id_q;
        tc_d         = tc_q;
        done_d       = done_q;

        comp   = core_start_q & bus.core_done;
        n_comp = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            n_comp = n_comp + DATA_W'(comp[i]);
        end

        new_total = blocks_for(bus.thread_count, TPB_LOG2);
        // Threads already covered by the full blocks ahead of the final one.
        last_base = 16'(total_q - 8'd1) << TPB_LOG2;
        last_tc   = TCW'(count_q - last_base[DATA_W-1:0]);
        sel       = int'(pick_idx);

        case (state_q)
            DISP_IDLE: begin
                if (bus.start) begin
                    total_d      = new_total;
                    count_d      = bus.thread_count;
                    dispatched_d = '0;
                    completed_d  = '0;
                    if (new_total == '0) begin
                        state_d = DISP_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DISP_RUN;
                    end
                end
            end

            DISP_RUN: begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (comp[i]) begin
                        core_start_d[i] = 1'b0;
                        core_reset_d[i] = 1'b1;
                    end
                end
                completed_d = completed_q + n_comp;

                // The picker sees registered core_reset, so a core freed on this
                // edge is only eligible from the next one.
                if (pick_valid && (dispatched_q < total_q)) begin
                    core_reset_d[sel]                  = 1'b0;
                    core_start_d[sel]                  = 1'b1;
                    block_id_d[sel*DATA_W +: DATA_W]   = dispatched_q;
                    tc_d[sel*TCW +: TCW]               = (dispatched_q == total_q - 8'd1)
                                                         ? last_tc : FULL_TC;
                    dispatched_d                       = dispatched_q + 8'd1;
                end

                if (completed_d == total_q) begin
                    state_d      = DISP_DONE;
                    done_d       = 1'b1;
                    core_reset_d = '1;
                    core_start_d = '0;
                end
            end

            DISP_DONE: begin
                core_reset_d = '1;
                core_start_d = '0;
                if (!bus.start) begin
                    state_d = DISP_IDLE;
                    done_d  = 1'b0;
                end
            end

            default: begin
                state_d = DISP_IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= DISP_IDLE;
            total_q      <= '0;
            count_q      <= '0;
            dispatched_q <= '0;
            completed_q  <= '0;
            core_start_q <= '0;
            core_reset_q <= '1;
            block_id_q   <= '0;
            tc_q         <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            count_q      <= count_d;
            dispatched_q <= dispatched_d;
            completed_q  <= completed_d;
            core_start_q <= core_start_d;
            core_reset_q <= core_reset_d;
            block_id_q   <= block_id_d;
            tc_q         <= tc_d;
            done_q       <= done_d;
        end
    end

    assign bus.core_start        = core_start_q;
    assign bus.core_reset        = core_reset_q;
    assign bus.core_block_id     = block_id_q;
    assign bus.core_thread_count = tc_q;
    assign bus.done              = done_q;
    assign bus.dbg_state         = state_q;

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher with 2 cores and 4 threads per block.
module tb_block_dispatcher;
  import block_dispatcher_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  block_dispatcher_if #(.NUM_CORES(2), .THREADS_PER_BLOCK(4)) bus ();

  block_dispatcher #(.NUM_CORES(2), .THREADS_PER_BLOCK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.thread_count = 8'd0;
    bus.core_done = 2'b00;
    #12;
    checks++;
    if (bus.core_reset !== 2'b11) begin errors++; $display("FAIL reset_core_reset: got %b expected 11", bus.core_reset); end
    checks++;
    if (bus.core_start !== 2'b00) begin errors++; $display("FAIL reset_core_start: got %b expected 00", bus.core_start); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++;
    if (bus.core_block_id !== 16'h0000 || bus.core_thread_count !== 6'd0) begin
      errors++; $display("FAIL reset_ids: got id %h tc %h expected 0 0", bus.core_block_id, bus.core_thread_count);
    end
    checks++;
    if (bus.dbg_state !== DISP_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.dbg_state); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full_blocks();
    bus.thread_count = 8'd8;
    bus.start = 1'b1;
    tick();
    checks++;
    if (bus.dbg_state !== DISP_RUN || bus.core_start !== 2'b00) begin
      errors++; $display("FAIL t1_launch: got state %0d start %b expected 1 00", bus.dbg_state, bus.core_start);
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.core_start !== 2'b01 || bus.core_block_id[7:0] !== 8'd0 || bus.core_thread_count[2:0] !== 3'd4) begin
      errors++; $display("FAIL t1_first: got start %b id %0d tc %0d expected 01 0 4",
                         bus.core_start, bus.core_block_id[7:0], bus.core_thread_count[2:0]);
    end
    tick();
    checks++;
    if (bus.core_start !== 2'b11 || bus.core_block_id[15:8] !== 8'd1 || bus.core_thread_count[5:3] !== 3'd4) begin
      errors++; $display("FAIL t1_second: got start %b id %0d tc %0d expected 11 1 4",
                         bus.core_start, bus.core_block_id[15:8], bus.core_thread_count[5:3]);
    end
    bus.core_done = 2'b11;
    tick();
    bus.core_done = 2'b00;
    checks++;
    if (bus.done !== 1'b1 || bus.core_start !== 2'b00 || bus.core_reset !== 2'b11) begin
      errors++; $display("FAIL t1_done: got done %b start %b reset %b expected 1 00 11", bus.done, bus.core_start, bus.core_reset);
    end
    checks++;
    if (bus.core_block_id !== 16'h0100) begin errors++; $display("FAIL t1_id_hold: got %h expected 0100", bus.core_block_id); end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.dbg_state !== DISP_IDLE) begin
      errors++; $display("FAIL t1_idle: got done %b state %0d expected 0 0", bus.done, bus.dbg_state);
    end
  endtask

  task automatic test_partial_block();
    bus.thread_count = 8'd10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.core_start !== 2'b11 || bus.core_block_id !== 16'h0100) begin
      errors++; $display("FAIL t2_two_running: got start %b id %h expected 11 0100", bus.core_start, bus.core_block_id);
    end
    bus.core_done = 2'b10;
    tick();
    bus.core_done = 2'b00;
    checks++;
    if (bus.core_start !== 2'b01 || bus.core_reset !== 2'b10) begin
      errors++; $display("FAIL t2_core1_free: got start %b reset %b expected 01 10", bus.core_start, bus.core_reset);
    end
    tick();
    checks++;
    if (bus.core_start !== 2'b11 || bus.core_block_id[15:8] !== 8'd2 || bus.core_thread_count[5:3] !== 3'd2) begin
      errors++; $display("FAIL t2_last_block: got start %b id %0d tc %0d expected 11 2 2",
                         bus.core_start, bus.core_block_id[15:8], bus.core_thread_count[5:3]);
    end
    bus.core_done = 2'b11;
    tick();
    bus.core_done = 2'b00;
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL t2_done: got %b expected 1", bus.done); end
    tick();
  endtask

  task automatic test_zero_threads();
    bus.thread_count = 8'd0;
    bus.start = 1'b1;
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.dbg_state !== DISP_DONE || bus.core_start !== 2'b00) begin
      errors++; $display("FAIL t3_done: got done %b state %0d start %b expected 1 2 00", bus.done, bus.dbg_state, bus.core_start);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.core_start !== 2'b00) begin
      errors++; $display("FAIL t3_hold: got done %b start %b expected 1 00", bus.done, bus.core_start);
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.dbg_state !== DISP_IDLE) begin
      errors++; $display("FAIL t3_release: got done %b state %0d expected 0 0", bus.done, bus.dbg_state);
    end
  endtask

  task automatic test_dual_complete();
    bus.thread_count = 8'd16;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.core_done = 2'b11;
    tick();
    bus.core_done = 2'b00;
    checks++;
    if (bus.core_start !== 2'b00 || bus.core_reset !== 2'b11 || bus.done !== 1'b0) begin
      errors++; $display("FAIL t4_both_free: got start %b reset %b done %b expected 00 11 0", bus.core_start, bus.core_reset, bus.done);
    end
    tick();
    checks++;
    if (bus.core_start !== 2'b01 || bus.core_block_id[7:0] !== 8'd2) begin
      errors++; $display("FAIL t4_redisp0: got start %b id %0d expected 01 2", bus.core_start, bus.core_block_id[7:0]);
    end
    tick();
    checks++;
    if (bus.core_start !== 2'b11 || bus.core_block_id[15:8] !== 8'd3) begin
      errors++; $display("FAIL t4_redisp1: got start %b id %0d expected 11 3", bus.core_start, bus.core_block_id[15:8]);
    end
    bus.core_done = 2'b11;
    tick();
    bus.core_done = 2'b00;
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL t4_done: got %b expected 1", bus.done); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bus.thread_count = 8'd8;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.core_reset !== 2'b11 || bus.core_start !== 2'b00 || bus.done !== 1'b0 || bus.dbg_state !== DISP_IDLE) begin
      errors++; $display("FAIL t5_async: got reset %b start %b done %b state %0d expected 11 00 0 0",
                         bus.core_reset, bus.core_start, bus.done, bus.dbg_state);
    end
    checks++;
    if (bus.core_block_id !== 16'h0000) begin errors++; $display("FAIL t5_ids: got %h expected 0000", bus.core_block_id); end
    @(negedge clk);
    reset = 1'b0;
    bus.thread_count = 8'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.core_start !== 2'b01 || bus.core_block_id[7:0] !== 8'd0 || bus.core_thread_count[2:0] !== 3'd4) begin
      errors++; $display("FAIL t5_restart: got start %b id %0d tc %0d expected 01 0 4",
                         bus.core_start, bus.core_block_id[7:0], bus.core_thread_count[2:0]);
    end
    bus.core_done = 2'b01;
    tick();
    bus.core_done = 2'b00;
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL t5_done: got %b expected 1", bus.done); end
    tick();
  endtask

  task automatic test_max_threads();
    int exp_id;
    int cycles;
    logic [7:0] id;
    logic [2:0] tc;
    exp_id = 0;
    cycles = 0;
    bus.thread_count = 8'd255;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.thread_count = 8'd8;
    while (bus.done !== 1'b1 && cycles < 400) begin
      tick();
      cycles++;
      for (int i = 0; i < 2; i++) begin
        if (bus.core_start[i]) begin
          id = bus.core_block_id[8*i +: 8];
          tc = bus.core_thread_count[3*i +: 3];
          checks++;
          if (id !== 8'(exp_id) || tc !== ((exp_id == 63) ? 3'd3 : 3'd4)) begin
            errors++; $display("FAIL t6_block: core %0d got id %0d tc %0d expected id %0d tc %0d",
                               i, id, tc, exp_id, (exp_id == 63) ? 3 : 4);
          end
          exp_id++;
        end
      end
      bus.core_done = bus.core_start;
    end
    bus.core_done = 2'b00;
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL t6_timeout: got done %b after %0d cycles expected 1", bus.done, cycles); end
    checks++;
    if (exp_id !== 64) begin errors++; $display("FAIL t6_count: got %0d blocks expected 64", exp_id); end
    tick();
    checks++;
    if (bus.dbg_state !== DISP_IDLE) begin errors++; $display("FAIL t6_idle: got %0d expected 0", bus.dbg_state); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_blocks();
    test_partial_block();
    test_zero_threads();
    test_dual_complete();
    test_reset_mid_run();
    test_max_threads();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
